eac_cksum_sched: RTL



---
 rtl/eac_cksum_pkg.sv | 32 +++
 rtl/J16_node_adder.sv | 12 +
 rtl/eac_rr_arb.sv | 36 +++
 rtl/eac_cksum_sched.sv | 108 ++++++++++
 4 files changed

// File: rtl/eac_cksum_pkg.sv
// Shared types and the round-robin pick function for the checksum scheduler.
package eac_cksum_pkg;
    localparam int W     = 16;
    localparam int MAXCH = 8;

    typedef logic [W-1:0] word_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of elig at or after ptr, wrapping within nch channels.
    function automatic pick_t rr_pick(input logic [MAXCH-1:0] elig,
                                      input logic [2:0]       ptr,
                                      input int               nch);
        pick_t p;
        int    c;
        p = '0;
        for (int i = 0; i < MAXCH; i++) begin
            if (i < nch) begin
                c = int'(ptr) + i;
                if (c >= nch) c = c - nch;
                if (!p.found && elig[c]) begin
                    p.found = 1'b1;
                    p.idx   = 3'(c);
                end
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/J16_node_adder.sv
// 16-bit end-around-carry adder (mod 2^16-1); carry out of bit 15 re-enters at bit 0.
module J16_node_adder (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum
);
    logic [16:0] w_raw;

    assign w_raw = {1'b0, i_a} + {1'b0, i_b};
    // One wrap suffices: with a carry the low half is at most 0xFFFE.
    assign o_sum = w_raw[15:0] + {15'b0, w_raw[16]};
endmodule

// File: rtl/eac_rr_arb.sv
// Round-robin arbiter: combinational grant from the pointer, pointer moves past the winner on i_adv.
module eac_rr_arb
    import eac_cksum_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int IW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] i_elig,
    input  logic           i_adv,
    output logic [NCH-1:0] o_gnt_oh,
    output logic [IW-1:0]  o_idx,
    output logic           o_found
);
    logic [IW-1:0]    r_ptr;
    logic [MAXCH-1:0] w_elig8;
    pick_t            w_pick;

    always_comb begin
        w_elig8             = '0;
        w_elig8[NCH-1:0]    = i_elig;
        w_pick              = rr_pick(w_elig8, 3'(r_ptr), NCH);
    end

    assign o_found  = w_pick.found;
    assign o_idx    = w_pick.idx[IW-1:0];
    assign o_gnt_oh = o_found ? (NCH'(1) << o_idx) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (i_adv)
            r_ptr <= (o_idx == IW'(NCH - 1)) ? '0 : o_idx + IW'(1);
    end
endmodule

// File: rtl/eac_cksum_sched.sv
// Time-shares one end-around-carry adder across NCH streaming checksum channels.
// Optional per-packet word count output enabled by EAC_CKSUM_WORDCNT_EN.
module eac_cksum_sched
    import eac_cksum_pkg::*;
#(
    parameter  int NCH = 4,
    parameter  int W   = 16,
    localparam int CW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   req_valid,
    output logic [NCH-1:0]   req_ready,
    input  logic [NCH*W-1:0] req_data,
    input  logic [NCH-1:0]   req_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CW-1:0]    res_ch,
    output logic [W-1:0]     res_cksum
`ifdef EAC_CKSUM_WORDCNT_EN
    ,
    output logic [15:0]      res_words
`endif
);
    if (W != 16) begin : g_bad_w
        $error("eac_cksum_sched: W must be 16");
    end
    if (NCH < 2 || NCH > 8) begin : g_bad_nch
        $error("eac_cksum_sched: NCH must be 2..8");
    end

    word_t          r_acc [NCH];
    logic [NCH-1:0] r_busy;

    logic           w_slot_free;
    logic [NCH-1:0] w_elig;
    logic [NCH-1:0] w_gnt_oh;
    logic [CW-1:0]  w_gnt;
    logic           w_xfer;
    logic           w_last;
    word_t          w_a;
    word_t          w_b;
    word_t          w_sum;

    // Last words need the result register; others always proceed.
    assign w_slot_free = !res_valid || res_ready;
    assign w_elig      = req_valid & (~req_last | {NCH{w_slot_free}});

    eac_rr_arb #(.NCH(NCH)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_elig   (w_elig),
        .i_adv    (w_xfer),
        .o_gnt_oh (w_gnt_oh),
        .o_idx    (w_gnt),
        .o_found  (w_xfer)
    );

    assign req_ready = w_gnt_oh;
    assign w_last    = req_last[w_gnt];
    assign w_a       = r_busy[w_gnt] ? r_acc[w_gnt] : '0;
    assign w_b       = req_data[w_gnt*W +: W];

    J16_node_adder u_add (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
            r_busy    <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_cksum <= '0;
        end else if (w_xfer && w_last) begin
            res_valid      <= 1'b1;
            res_ch         <= w_gnt;
            res_cksum      <= ~w_sum;
            r_acc[w_gnt]   <= '0;
            r_busy[w_gnt]  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_acc[w_gnt]  <= w_sum;
                r_busy[w_gnt] <= 1'b1;
            end
            if (res_valid && res_ready) res_valid <= 1'b0;
        end
    end

`ifdef EAC_CKSUM_WORDCNT_EN
    logic [15:0] r_cnt [NCH];
    logic [15:0] w_cnt_nxt;

    assign w_cnt_nxt = (&r_cnt[w_gnt]) ? r_cnt[w_gnt] : r_cnt[w_gnt] + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) r_cnt[c] <= '0;
            res_words <= '0;
        end else if (w_xfer) begin
            r_cnt[w_gnt] <= w_last ? 16'd0 : w_cnt_nxt;
            if (w_last) res_words <= w_cnt_nxt;
        end
    end
`endif
endmodule
